// File: rtl/s_mem_pkg.sv
// Shared S-array types and requester indices for the cipher-engine RAM arbiter.
package s_mem_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef logic [S_ADDR_W-1:0] s_addr_t;
    typedef logic [S_DATA_W-1:0] s_data_t;

    localparam int REQ_INIT    = 0;
    localparam int REQ_SHUFFLE = 1;
    localparam int REQ_DECRYPT = 2;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/s_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        win     = '0;
        win_idx = '0;
        win_vld = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'((int'(ptr) + k) % N);
            if (!win_vld && req[pos]) begin
                win_vld  = 1'b1;
                win[pos] = 1'b1;
                win_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/s_mem_arbiter.sv
// Round-robin arbiter with lock for the single-port S-array RAM.
// Optional per-requester grant counters when S_MEM_ARB_PERF_EN is defined.
module s_mem_arbiter
    import s_mem_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = S_ADDR_W,
    parameter int DATA_W  = S_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        wren,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_q
`ifdef S_MEM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]     perf_gnt_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               owner_vld_q, owner_vld_d;
    logic [IDX_W-1:0]   owner_idx_q, owner_idx_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic [NUM_REQ-1:0] pick_win;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               owned;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    // An owner that drops req releases the RAM to normal arbitration in the same cycle.
    assign owned = owner_vld_q && req[owner_idx_q];

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (reset_n) begin
            if (owned) begin
                gnt     = NUM_REQ'(1) << owner_idx_q;
                gnt_vld = 1'b1;
                gnt_idx = owner_idx_q;
            end else if (pick_vld) begin
                gnt     = pick_win;
                gnt_vld = 1'b1;
                gnt_idx = pick_idx;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (gnt_vld) begin
            mem_addr = addr[gnt_idx*ADDR_W +: ADDR_W];
            mem_data = wdata[gnt_idx*DATA_W +: DATA_W];
            mem_wren = wren[gnt_idx];
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_vld_d = 1'b0;
        owner_idx_d = owner_idx_q;
        rvalid_d    = gnt & ~wren;
        if (gnt_vld) begin
            rr_ptr_d    = IDX_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
            owner_vld_d = lock[gnt_idx];
            owner_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            owner_vld_q <= 1'b0;
            owner_idx_q <= '0;
            rvalid_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_vld_q <= owner_vld_d;
            owner_idx_q <= owner_idx_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = mem_q;

`ifdef S_MEM_ARB_PERF_EN
    logic [15:0] perf_cnt_q [NUM_REQ];
    logic [15:0] perf_cnt_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_cnt_d[i] = perf_cnt_q[i];
            if (gnt[i] && (perf_cnt_q[i] != 16'hFFFF)) begin
                perf_cnt_d[i] = perf_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) perf_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) perf_cnt_q[i] <= perf_cnt_d[i];
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_out
        assign perf_gnt_cnt[g*16 +: 16] = perf_cnt_q[g];
    end
`endif

endmodule

// File: doc/s_mem_arbiter.md
# s_mem_arbiter

Shares the single-port 256×8 S-array RAM between the cipher-engine requesters: array fill, key-schedule shuffle and message decrypt. Each cycle it grants at most one requester in round-robin order, with a lock option so one requester can hold a read-modify-write swap without interruption. It sits between the engines and the RAM, and returns read data with a per-requester valid strobe. It replaces ad-hoc priority muxing with a fair, verifiable arbitration point.

## Interface
- `NUM_REQ`, default 3: number of requesters; legal range 2..8.
- `ADDR_W`, default 8: S-array address width.
- `DATA_W`, default 8: S-array data width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: per-requester access request; level, held until granted.
- `lock` in NUM_REQ: when granted with lock high, keep ownership for following cycles.
- `wren` in NUM_REQ: per-requester write enable (1 = write, 0 = read).
- `addr` in NUM_REQ×ADDR_W: packed per-requester address; slot i at `[i*ADDR_W +: ADDR_W]`.
- `wdata` in NUM_REQ×DATA_W: packed per-requester write data.
- `gnt` out NUM_REQ: one-hot grant. Combinational; the access is issued this cycle.
- `rvalid` out NUM_REQ: one-hot, high for one cycle when `rdata` holds that requester's read.
- `rdata` out DATA_W: broadcast of `mem_q`.
- `mem_addr` out ADDR_W: RAM address.
- `mem_data` out DATA_W: RAM write data.
- `mem_wren` out 1: RAM write enable.
- `mem_q` in DATA_W: RAM read data; valid one cycle after the address is presented.

## Operation
- **State:**
  - `rr_ptr` (log2 NUM_REQ bits).
  - `owner_vld`, `owner_idx`.
  - `rvalid` register.
- **Owned cycle:** if `owner_vld` and `req[owner_idx]`=1, then `gnt` = one-hot(`owner_idx`) regardless of other requests.
- **Owner drops request:** if `owner_vld` and `req[owner_idx]`=0, ownership is cleared that cycle and normal arbitration applies in the same cycle.
- **Normal arbitration:** scan `req` starting at `rr_ptr`, ascending, wrapping modulo NUM_REQ. The first set bit wins.
- **Pointer update:** on any grant to index g, `rr_ptr` ← (g+1) mod NUM_REQ. This includes owned cycles.
- **Lock handling:**
  - Granted g with `lock[g]`=1: `owner_vld`←1, `owner_idx`←g.
  - Granted g with `lock[g]`=0: `owner_vld`←0.
- **Memory drive when granted g:** `mem_addr`=`addr[g]`, `mem_data`=`wdata[g]`, `mem_wren`=`wren[g]`.
- **Memory drive with no grant:** `mem_addr`=0, `mem_data`=0, `mem_wren`=0.
- **Read valid:** `rvalid` next = `gnt` & ~`wren`, so it is asserted the cycle after a granted read.
- **Writes:** produce no `rvalid`.

## Timing
- **Reset values:** `rr_ptr`=0, `owner_vld`=0, `rvalid`=0. While `reset_n`=0, `gnt`=0 and `mem_wren`=0.
- **Grant latency:** 0 cycles. A request is granted in the same cycle it is asserted if it wins arbitration.
- **Read latency:** 1 cycle from grant to `rvalid`/`rdata`.
- **Back-to-back accesses:** one access per cycle; full throughput.
- **Worst-case wait:** with no locks, NUM_REQ−1 cycles. With locks, waiting is unbounded while an owner holds both `req` and `lock`.
- **Swap sequence:** a locked sequence read i, read j, write i, write j occupies 4 consecutive cycles with no interleaving.
- **Requests during reset:** ignored. After release, arbitration starts at index 0.
- **Reset mid-lock:** ownership is lost and any pending `rvalid` is dropped.
- **Requester rule:** must not change `addr`/`wren`/`wdata` while `req` is high and ungranted.

## Configuration
- **`S_MEM_ARB_PERF_EN` defined:** adds output `perf_gnt_cnt` (NUM_REQ×16).
  - Holds per-requester 16-bit saturating counters of granted cycles.
  - Counters are cleared by reset and stick at 0xFFFF.
- **Undefined:** the port and counters are absent. Arbitration behaviour is identical either way.

## Structure
- **Package `s_mem_pkg`:**
  - `S_ADDR_W`=8, `S_DATA_W`=8.
  - typedefs `s_addr_t`, `s_data_t`.
  - requester index constants `REQ_INIT`=0, `REQ_SHUFFLE`=1, `REQ_DECRYPT`=2.
- **Sub-module `rr_pick`:** combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot winner and its index.
  - `s_mem_arbiter` instantiates it once.

## Test plan
- **Single write:** `req`=001, `wren[0]`=1, `addr[0]`=0x10, `wdata[0]`=0xAB → same cycle `gnt`=001, `mem_wren`=1, `mem_addr`=0x10, `mem_data`=0xAB; `rvalid` stays 0.
- **Single read:** RAM[0x10]=0xAB; requester 2 reads 0x10 → `gnt`=100 that cycle; next cycle `rvalid`=100, `rdata`=0xAB.
- **Round-robin:** `req`=111 held with no locks, out of reset → grants 001,010,100,001,… in consecutive cycles.
- **Locked swap:** requester 1 asserts `lock` for 4 cycles while `req`=111 → `gnt`=010 for all 4 cycles. `lock` drops on the 4th, so `gnt`=100 next.
- **Owner drops request:** owner drops `req` while owned → another requester is granted in that same cycle.
- **Reset mid-lock:** `reset_n` pulsed low → `gnt`=0, `rvalid`=0, owner cleared. The first post-reset grant with `req`=110 is 010.
